// File: rtl/msp_spi_slave.sv
// Half-duplex SPI slave: oversampled spi_clk, command in, turnaround, response out
// on the shared data line, with ready/valid handshakes and an inactivity timeout.
module msp_spi_slave #(
  parameter int CMD_W        = 64,
  parameter int RESP_W       = 128,
  parameter int TURN_BITS    = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_din,
  output logic              spi_dout,
  output logic              spi_oe,
  output logic [CMD_W-1:0]  cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic [RESP_W-1:0] resp_data,
  input  logic              resp_valid,
  output logic              resp_ready,
  output logic              resp_late,
  output logic              spi_rst_,
  output logic              busy
);
  localparam int MAX_CR = (CMD_W > RESP_W) ? CMD_W : RESP_W;
  localparam int MAX_B  = (MAX_CR > TURN_BITS) ? MAX_CR : TURN_BITS;
  localparam int BW     = $clog2(MAX_B + 1);
  localparam int TW     = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, CMD, TURN, RESP} state_t;

  state_t state, nxt;

  logic [SYNC_STAGES-1:0] sclk_sync, din_sync;
  logic                   sclk_q;
  logic                   sclk_s, din_s, rise, fall;
  logic [BW-1:0]          bit_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [CMD_W-1:0]       cmd_sr;
  logic [RESP_W-1:0]      out_sr;
  logic                   resp_loaded;
  logic                   cmd_last, turn_last, resp_last, tmo_hit, resp_take;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign din_s  = din_sync[SYNC_STAGES-1];
  assign rise   = sclk_s & ~sclk_q;
  assign fall   = ~sclk_s & sclk_q;

  assign cmd_last  = (state == CMD)  && rise && (bit_cnt == BW'(CMD_W - 1));
  assign turn_last = (state == TURN) && rise && (bit_cnt == BW'(TURN_BITS - 1));
  assign resp_last = (state == RESP) && rise && (bit_cnt == BW'(RESP_W - 1));
  // An spi_clk edge in the terminal cycle keeps the frame alive.
  assign tmo_hit   = (state != IDLE) && !(rise || fall) && (tmo_cnt == TW'(IDLE_TIMEOUT - 1));
  assign resp_take = resp_valid && resp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      din_sync  <= '0;
      sclk_q    <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], spi_din};
      sclk_q    <= sclk_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (tmo_hit) nxt = IDLE;
    else begin
      case (state)
        IDLE: if (rise)      nxt = CMD;
        CMD:  if (cmd_last)  nxt = TURN;
        TURN: if (turn_last) nxt = RESP;
        RESP: if (resp_last) nxt = IDLE;
        default:             nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    spi_rst_   = (state != IDLE);
    busy       = spi_rst_;
    resp_ready = (state == TURN) && !cmd_valid && !resp_loaded;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      cmd_sr      <= '0;
      out_sr      <= '0;
      resp_loaded <= 1'b0;
      cmd_data    <= '0;
      cmd_valid   <= 1'b0;
      spi_dout    <= 1'b0;
      spi_oe      <= 1'b0;
      resp_late   <= 1'b0;
    end else begin
      resp_late <= 1'b0;
      if (state == IDLE || rise || fall || tmo_hit) tmo_cnt <= '0;
      else                                          tmo_cnt <= tmo_cnt + TW'(1);
      if (cmd_valid && cmd_ready) cmd_valid <= 1'b0;

      if (tmo_hit) begin
        bit_cnt     <= '0;
        cmd_sr      <= '0;
        out_sr      <= '0;
        resp_loaded <= 1'b0;
        spi_oe      <= 1'b0;
        spi_dout    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (rise) begin
            cmd_sr      <= {cmd_sr[CMD_W-2:0], din_s};
            bit_cnt     <= BW'(1);
            resp_loaded <= 1'b0;
          end
          CMD: if (rise) begin
            if (cmd_last) begin
              // A fresh load overrides a same-cycle accept of the previous command.
              cmd_data  <= {cmd_sr[CMD_W-2:0], din_s};
              cmd_valid <= 1'b1;
              cmd_sr    <= '0;
              bit_cnt   <= '0;
            end else begin
              cmd_sr  <= {cmd_sr[CMD_W-2:0], din_s};
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
          TURN: begin
            if (resp_take) begin
              out_sr      <= resp_data;
              resp_loaded <= 1'b1;
            end
            if (rise) begin
              if (turn_last) begin
                bit_cnt <= '0;
                if (!resp_loaded && !resp_take) begin
                  out_sr    <= '0;
                  resp_late <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          RESP: begin
            if (fall) begin
              spi_oe   <= 1'b1;
              spi_dout <= out_sr[RESP_W-1];
              out_sr   <= out_sr << 1;
            end
            if (rise) begin
              if (resp_last) begin
                spi_oe      <= 1'b0;
                spi_dout    <= 1'b0;
                bit_cnt     <= '0;
                out_sr      <= '0;
                resp_loaded <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_msp_spi_slave.sv
// Self-checking bench for msp_spi_slave: table of full frames plus hand-written
// sequences for handshake hold, timeout, glitch, edge-at-terminal-count and reset.
module tb_msp_spi_slave;
  localparam int HALF = 6;

  logic         clk = 1'b0, rst = 1'b1;
  logic         spi_clk = 1'b0, spi_din = 1'b0;
  logic         spi_dout, spi_oe;
  logic [63:0]  cmd_data;
  logic         cmd_valid, cmd_ready = 1'b0;
  logic [127:0] resp_data = '0;
  logic         resp_valid = 1'b0;
  logic         resp_ready, resp_late, spi_rst_, busy;

  msp_spi_slave #(.CMD_W(64), .RESP_W(128), .TURN_BITS(8), .SYNC_STAGES(2), .IDLE_TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_din(spi_din), .spi_dout(spi_dout), .spi_oe(spi_oe),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_late(resp_late), .spi_rst_(spi_rst_), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  cmd;
    logic [127:0] resp;
    bit           on_time;
    logic [127:0] exp_resp;
    int           exp_late;
  } vec_t;

  int           checks = 0, failures = 0, late_cnt = 0;
  logic [63:0]  cmd_q[$];
  logic [127:0] resp_q[$];
  vec_t         vecs[4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Command scoreboard: compare on every accepted handshake.
  always @(negedge clk) begin
    #3;
    if (!rst && resp_late) late_cnt++;
    if (!rst && cmd_valid && cmd_ready) begin
      if (cmd_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL cmd_unexpected: got %0h expected none", cmd_data);
      end else chk("cmd_data", {64'h0, cmd_data}, {64'h0, cmd_q.pop_front()});
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic spi_cycle(input logic din, output logic dout, output logic oe);
    spi_clk = 1'b0; spi_din = din;
    repeat (HALF) @(negedge clk);
    #1; dout = spi_dout; oe = spi_oe;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [63:0] c, input int from, input int to);
    logic d, o;
    for (int i = from; i >= to; i--) spi_cycle(c[i], d, o);
  endtask

  task automatic send_cmd(input logic [63:0] c, output int lat);
    cmd_q.push_back(c);
    send_bits(c, 63, 1);
    spi_clk = 1'b0; spi_din = c[0];
    repeat (HALF) @(negedge clk);
    #1; spi_clk = 1'b1;
    lat = 0;
    while (!cmd_valid && lat < HALF) begin
      @(negedge clk); #1; lat++;
    end
    repeat (HALF - lat) @(negedge clk);
    #1;
  endtask

  task automatic do_turn(input int n);
    logic d, o;
    for (int i = 0; i < n; i++) spi_cycle(1'b0, d, o);
  endtask

  task automatic read_resp(input int n, output logic [127:0] w, output int oe_bad);
    logic d, o;
    w = '0; oe_bad = 0;
    for (int i = 0; i < n; i++) begin
      spi_cycle(1'b0, d, o);
      w = {w[126:0], d};
      if (o !== 1'b1) oe_bad++;
    end
  endtask

  task automatic end_frame();
    spi_clk = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("oe_after_frame", spi_oe, 0);
    chk("busy_after_frame", busy, 0);
  endtask

  task automatic finish_frame(input vec_t v);
    logic [127:0] w;
    int bad, l0;
    l0 = late_cnt;
    if (v.on_time) begin resp_data = v.resp; resp_valid = 1'b1; end
    resp_q.push_back(v.exp_resp);
    do_turn(2);
    chk("resp_ready_turn", resp_ready, !v.on_time);
    do_turn(6);
    resp_valid = 1'b0;
    chk("resp_late_count", late_cnt - l0, v.exp_late);
    read_resp(128, w, bad);
    chk("resp_word", w, resp_q.pop_front());
    chk("resp_oe_during", bad, 0);
    end_frame();
  endtask

  task automatic run_frame(input vec_t v);
    int lat;
    send_cmd(v.cmd, lat);
    finish_frame(v);
  endtask

  initial begin
    int lat, bad;
    logic [127:0] w;
    vec_t v;

    vecs[0] = '{64'h0123456789ABCDEF, 128'hFFEEDDCCBBAA99887766554433221100, 1'b1,
                128'hFFEEDDCCBBAA99887766554433221100, 0};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 128'h0, 1'b1, 128'h0, 0};
    vecs[2] = '{64'hA5A5A5A55A5A5A5A, 128'hDEADDEADDEADDEADDEADDEADDEADDEAD, 1'b0, 128'h0, 1};
    vecs[3] = '{64'h8000000000000001, 128'h80000000000000000000000000000001, 1'b1,
                128'h80000000000000000000000000000001, 0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_spi_oe", spi_oe, 0);
    chk("rst_spi_dout", spi_dout, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_resp_late", resp_late, 0);
    chk("rst_spi_rst_", spi_rst_, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;

    // Command with consumer stalled, then accepted; response latched in turnaround
    send_cmd(64'hDEADBEEF01234567, lat);
    chk("cmd_latency_ok", (lat >= 2 && lat <= 3), 1);
    chk("cmd_valid_rise", cmd_valid, 1);
    chk("cmd_data_direct", cmd_data, 64'hDEADBEEF01234567);
    chk("busy_in_turn", busy, 1);
    do_turn(2);
    chk("cmd_valid_hold", cmd_valid, 1);
    chk("resp_ready_blocked", resp_ready, 0);
    cmd_ready = 1'b1;
    @(negedge clk); #1;
    chk("cmd_valid_clear", cmd_valid, 0);
    chk("resp_ready_open", resp_ready, 1);
    resp_data = 128'h0123456789ABCDEFFEDCBA9876543210;
    resp_valid = 1'b1;
    resp_q.push_back(128'h0123456789ABCDEFFEDCBA9876543210);
    @(negedge clk); #1;
    chk("resp_ready_after_latch", resp_ready, 0);
    do_turn(6);
    resp_valid = 1'b0;
    read_resp(128, w, bad);
    chk("resp_word_hand", w, resp_q.pop_front());
    chk("resp_oe_hand", bad, 0);
    end_frame();

    // Table-driven frames
    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Inactivity timeout after 20 command bits
    send_bits(64'hCAFEF00D12345678, 63, 44);
    spi_clk = 1'b0;
    repeat (1000) @(negedge clk);
    #1;
    chk("tmo_busy_before", busy, 1);
    repeat (40) @(negedge clk);
    #1;
    chk("tmo_spi_rst_", spi_rst_, 0);
    chk("tmo_busy", busy, 0);
    v = '{64'h1122334455667788, 128'h00112233445566778899AABBCCDDEEFF, 1'b1,
          128'h00112233445566778899AABBCCDDEEFF, 0};
    run_frame(v);

    // Sub-cycle glitch, then an edge landing on the timeout terminal count
    v = '{64'h0F1E2D3C4B5A6978, 128'hC3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3, 1'b1,
          128'hC3C3C3C3C3C3C3C3C3C3C3C3C3C3C3C3, 0};
    cmd_q.push_back(v.cmd);
    send_bits(v.cmd, 63, 45);
    spi_clk = 1'b0; spi_din = v.cmd[44];
    @(negedge clk); #1;
    spi_clk = 1'b1; #2; spi_clk = 1'b0;
    repeat (1023) @(negedge clk);
    #1; spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    #1;
    chk("tmo_edge_busy", busy, 1);
    send_bits(v.cmd, 43, 0);
    finish_frame(v);

    // Reset during the response at bit 50
    v = '{64'h5555AAAA5555AAAA, 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF, 1'b1, 128'h0, 0};
    send_cmd(v.cmd, lat);
    resp_data = v.resp; resp_valid = 1'b1;
    do_turn(8);
    resp_valid = 1'b0;
    read_resp(50, w, bad);
    chk("oe_before_rst", spi_oe, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_oe", spi_oe, 0);
    chk("mid_rst_dout", spi_dout, 0);
    chk("mid_rst_cmd_data", cmd_data, 0);
    chk("mid_rst_cmd_valid", cmd_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_spi_rst_", spi_rst_, 0);
    chk("mid_rst_resp_ready", resp_ready, 0);
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    #1; rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    v = '{64'h13579BDF2468ACE0, 128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 1'b1,
          128'h0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F0F, 0};
    run_frame(v);

    repeat (10) @(negedge clk);
    #1;
    chk("cmd_q_drained", cmd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
